cache_plru_ctrl: RTL and testbench

- Tree pseudo-LRU replacement controller for the set-associative cache.
- Sits directly upstream of the per-set replacement-state single-port register file and is its only master: it drives we/addr/w_data and consumes r_data (asynchronous read).
- Serves two requests:
  - touch: update recency on a hit or allocate.
  - victim: return the way to evict for a given set.
- The storage has a single shared address, so every access is serialized through a small FSM.

---
 rtl/cache_plru_ctrl.sv | 152 +++++++++++++++
 tb/tb_cache_plru_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_plru_ctrl.sv
// Tree pseudo-LRU replacement controller. Serializes touch updates and victim lookups
// through the single shared address of the per-set replacement-state register file.
module cache_plru_ctrl #(
    parameter int unsigned N_WAYS  = 4,
    parameter int unsigned NLINE_W = 2,
    localparam int unsigned PLRU_W = N_WAYS - 1
) (
    input  logic               ap_clk,
    input  logic               rst,
    input  logic               touch_valid,
    output logic               touch_ready,
    input  logic [NLINE_W-1:0] touch_set,
    input  logic [N_WAYS-1:0]  touch_way,
    input  logic               victim_req_valid,
    output logic               victim_req_ready,
    input  logic [NLINE_W-1:0] victim_set,
    output logic               victim_rsp_valid,
    input  logic               victim_rsp_ready,
    output logic [N_WAYS-1:0]  victim_way,
    output logic               rf_we,
    output logic [NLINE_W-1:0] rf_addr,
    output logic [PLRU_W-1:0]  rf_w_data,
    input  logic [PLRU_W-1:0]  rf_r_data
);

    localparam int unsigned IDX_W = $clog2(N_WAYS);

    typedef enum logic [1:0] {
        StIdle,
        StUpd,
        StLook,
        StRsp
    } state_e;

    state_e              state_q, state_d;
    logic [NLINE_W-1:0]  addr_q, addr_d;
    logic [N_WAYS-1:0]   way_q, way_d;
    logic [N_WAYS-1:0]   victim_q, victim_d;

    logic [IDX_W-1:0]    touch_idx;
    logic [IDX_W-1:0]    victim_idx;
    logic [PLRU_W-1:0]   tree_upd;
    logic [N_WAYS-1:0]   victim_calc;

    // Downward scan so the lowest set bit of a multi-hot way wins.
    always_comb begin
        touch_idx = '0;
        for (int i = N_WAYS - 1; i >= 0; i--) begin
            if (way_q[i]) begin
                touch_idx = IDX_W'(i);
            end
        end
    end

    // Heap layout: level l holds nodes (2**l)-1 .. (2**(l+1))-2; the path node at level l
    // is the one whose position equals the top l bits of the way index.
    always_comb begin
        tree_upd = rf_r_data;
        for (int l = 0; l < int'(IDX_W); l++) begin
            for (int p = 0; p < (1 << l); p++) begin
                if ((touch_idx >> (IDX_W - l)) == IDX_W'(p)) begin
                    tree_upd[(1 << l) - 1 + p] = ~touch_idx[IDX_W - 1 - l];
                end
            end
        end
    end

    always_comb begin
        victim_idx = '0;
        for (int l = 0; l < int'(IDX_W); l++) begin
            for (int p = 0; p < (1 << l); p++) begin
                if ((victim_idx >> (IDX_W - l)) == IDX_W'(p)) begin
                    victim_idx[IDX_W - 1 - l] = rf_r_data[(1 << l) - 1 + p];
                end
            end
        end
        victim_calc = N_WAYS'(1) << victim_idx;
    end

    always_ff @(posedge ap_clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            way_q    <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            way_q    <= way_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        way_d            = way_q;
        victim_d         = victim_q;
        touch_ready      = 1'b0;
        victim_req_ready = 1'b0;
        victim_rsp_valid = 1'b0;
        rf_we            = 1'b0;
        rf_w_data        = '0;

        unique case (state_q)
            StIdle: begin
                touch_ready      = 1'b1;
                victim_req_ready = ~touch_valid;
                if (touch_valid) begin
                    addr_d  = touch_set;
                    way_d   = touch_way;
                    state_d = StUpd;
                end else if (victim_req_valid) begin
                    addr_d  = victim_set;
                    state_d = StLook;
                end
            end
            StUpd: begin
                // An empty way mask is accepted but leaves the set untouched.
                rf_we     = |way_q;
                rf_w_data = tree_upd;
                state_d   = StIdle;
            end
            StLook: begin
                victim_d = victim_calc;
                state_d  = StRsp;
            end
            StRsp: begin
                victim_rsp_valid = 1'b1;
                if (victim_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Reset is synchronous, so outputs are forced quiet while it is held.
        if (rst) begin
            touch_ready      = 1'b0;
            victim_req_ready = 1'b0;
            victim_rsp_valid = 1'b0;
            rf_we            = 1'b0;
            rf_w_data        = '0;
        end
    end

    assign rf_addr    = rst ? '0 : addr_q;
    assign victim_way = rst ? '0 : victim_q;

endmodule

// File: tb/tb_cache_plru_ctrl.sv
// Directed bench for cache_plru_ctrl with a behavioural replacement-state register file.
module tb_cache_plru_ctrl;

    logic       ap_clk = 1'b0;
    logic       rst;
    logic       touch_valid;
    logic       touch_ready;
    logic [1:0] touch_set;
    logic [3:0] touch_way;
    logic       victim_req_valid;
    logic       victim_req_ready;
    logic [1:0] victim_set;
    logic       victim_rsp_valid;
    logic       victim_rsp_ready;
    logic [3:0] victim_way;
    logic       rf_we;
    logic [1:0] rf_addr;
    logic [2:0] rf_w_data;
    logic [2:0] rf_r_data;

    logic [2:0] mem [4];
    int         errors = 0;
    int         checks = 0;

    always #5 ap_clk = ~ap_clk;

    always_ff @(posedge ap_clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else if (rf_we) begin
            mem[rf_addr] <= rf_w_data;
        end
    end

    assign rf_r_data = mem[rf_addr];

    cache_plru_ctrl #(
        .N_WAYS  (4),
        .NLINE_W (2)
    ) dut (
        .ap_clk           (ap_clk),
        .rst              (rst),
        .touch_valid      (touch_valid),
        .touch_ready      (touch_ready),
        .touch_set        (touch_set),
        .touch_way        (touch_way),
        .victim_req_valid (victim_req_valid),
        .victim_req_ready (victim_req_ready),
        .victim_set       (victim_set),
        .victim_rsp_valid (victim_rsp_valid),
        .victim_rsp_ready (victim_rsp_ready),
        .victim_way       (victim_way),
        .rf_we            (rf_we),
        .rf_addr          (rf_addr),
        .rf_w_data        (rf_w_data),
        .rf_r_data        (rf_r_data)
    );

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Issues one touch from IDLE and checks the UPD-cycle write.
    task automatic do_touch(input logic [1:0] set, input logic [3:0] way,
                            input logic exp_we, input logic [2:0] exp_data, input string name);
        touch_valid = 1'b1;
        touch_set   = set;
        touch_way   = way;
        #1;
        checks++;
        if (touch_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s touch_ready: got %b want 1", name, touch_ready);
        end
        tick();
        touch_valid = 1'b0;
        #1;
        checks++;
        if (rf_we !== exp_we || rf_addr !== set) begin
            errors++;
            $display("FAIL %s write: we=%b addr=%0d want we=%b addr=%0d",
                     name, rf_we, rf_addr, exp_we, set);
        end
        if (exp_we) begin
            checks++;
            if (rf_w_data !== exp_data) begin
                errors++;
                $display("FAIL %s w_data: got %b want %b", name, rf_w_data, exp_data);
            end
        end
        tick();
    endtask

    task automatic do_victim(input logic [1:0] set, input logic [3:0] exp_way,
                             input string name);
        victim_req_valid = 1'b1;
        victim_set       = set;
        #1;
        checks++;
        if (victim_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready: got %b want 1", name, victim_req_ready);
        end
        tick();
        victim_req_valid = 1'b0;
        #1;
        checks++;
        if (victim_rsp_valid !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL %s look: rsp_valid=%b we=%b want 0 0", name, victim_rsp_valid, rf_we);
        end
        tick();
        checks++;
        if (victim_rsp_valid !== 1'b1 || victim_way !== exp_way) begin
            errors++;
            $display("FAIL %s rsp: valid=%b way=%b want 1 %b",
                     name, victim_rsp_valid, victim_way, exp_way);
        end
        victim_rsp_ready = 1'b1;
        tick();
        victim_rsp_ready = 1'b0;
        #1;
        checks++;
        if (victim_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s rsp_drop: got %b want 0", name, victim_rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        touch_valid = 1'b0;
        touch_set = '0;
        touch_way = '0;
        victim_req_valid = 1'b0;
        victim_set = '0;
        victim_rsp_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({touch_ready, victim_req_ready, victim_rsp_valid, victim_way, rf_we, rf_addr,
             rf_w_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: tr=%b vr=%b rv=%b vw=%b we=%b a=%0d wd=%b want all 0",
                     touch_ready, victim_req_ready, victim_rsp_valid, victim_way, rf_we,
                     rf_addr, rf_w_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_victim_after_reset();
        do_victim(2'd0, 4'b0001, "victim_reset_set0");
        checks++;
        if (mem[0] !== 3'b000) begin
            errors++;
            $display("FAIL storage0_untouched: got %b want 000", mem[0]);
        end
    endtask

    task automatic test_touch();
        do_touch(2'd1, 4'b0001, 1'b1, 3'b011, "touch_s1_w0");
        checks++;
        if (rf_addr !== 2'd1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: addr=%0d we=%b want 1 0", rf_addr, rf_we);
        end
        do_victim(2'd1, 4'b0100, "victim_s1_a");
        do_touch(2'd1, 4'b0100, 1'b1, 3'b110, "touch_s1_w2");
        do_victim(2'd1, 4'b0010, "victim_s1_b");
        do_victim(2'd0, 4'b0001, "victim_s0_again");
    endtask

    task automatic test_priority();
        touch_valid      = 1'b1;
        touch_set        = 2'd2;
        touch_way        = 4'b0010;
        victim_req_valid = 1'b1;
        victim_set       = 2'd2;
        #1;
        checks++;
        if (touch_ready !== 1'b1 || victim_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_ready: tr=%b vr=%b want 1 0", touch_ready, victim_req_ready);
        end
        tick();
        touch_valid = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_w_data !== 3'b001 || victim_req_ready !== 1'b0
            || touch_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_upd: we=%b wd=%b vr=%b tr=%b want 1 001 0 0",
                     rf_we, rf_w_data, victim_req_ready, touch_ready);
        end
        tick();
        do_victim(2'd2, 4'b0100, "prio_victim");
    endtask

    task automatic test_stall();
        victim_req_valid = 1'b1;
        victim_set       = 2'd1;
        tick();
        victim_req_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (victim_rsp_valid !== 1'b1 || victim_way !== 4'b0010 || touch_ready !== 1'b0
                || victim_req_ready !== 1'b0 || rf_we !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: v=%b way=%b tr=%b vr=%b we=%b want 1 0010 0 0 0",
                         i, victim_rsp_valid, victim_way, touch_ready, victim_req_ready, rf_we);
            end
            tick();
        end
        victim_rsp_ready = 1'b1;
        tick();
        victim_rsp_ready = 1'b0;
        #1;
        checks++;
        if (victim_rsp_valid !== 1'b0 || touch_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: v=%b tr=%b want 0 1", victim_rsp_valid, touch_ready);
        end
    endtask

    task automatic test_reset_in_upd();
        touch_valid = 1'b1;
        touch_set   = 2'd3;
        touch_way   = 4'b0001;
        tick();
        touch_valid = 1'b0;
        rst         = 1'b1;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_w_data !== 3'b000 || rf_addr !== 2'd0) begin
            errors++;
            $display("FAIL rst_upd: we=%b wd=%b addr=%0d want 0 000 0", rf_we, rf_w_data, rf_addr);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (touch_ready !== 1'b1 || victim_rsp_valid !== 1'b0 || rf_we !== 1'b0
            || victim_way !== 4'b0000) begin
            errors++;
            $display("FAIL rst_idle: tr=%b v=%b we=%b way=%b want 1 0 0 0000",
                     touch_ready, victim_rsp_valid, rf_we, victim_way);
        end
        do_victim(2'd3, 4'b0001, "rst_victim_s3");
    endtask

    task automatic test_way_edges();
        do_touch(2'd1, 4'b0000, 1'b0, 3'b000, "touch_zero");
        do_victim(2'd1, 4'b0001, "zero_victim");
        do_touch(2'd0, 4'b1010, 1'b1, 3'b001, "touch_multi");
        do_victim(2'd0, 4'b0100, "multi_victim");
    endtask

    initial begin
        test_reset();
        test_victim_after_reset();
        test_touch();
        test_priority();
        test_stall();
        test_reset_in_upd();
        test_way_edges();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
